logicgates_sweep_ctrl: RTL and testbench
========================================

# logicgates_sweep_ctrl

Self-test sequencer for the `LogicGates` unit. On a start pulse it drives `sel`, `A` and `B` through all 16 combinations of gate select and operands, waits for the gate output to settle, and samples `Y` into a 16-bit truth-table register. It sits beside the `LogicGates` instance as its only driver during built-in self-test, then reports completion with a single-cycle pulse. Optionally it checks the captured table against the golden table and counts mismatches.

## Interface
**Parameters**
- `SETTLE_CYCLES`, default 1: cycles between driving a vector and sampling `Y`. Legal range 1..15.

**Ports**
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  sweep request; accepted only in IDLE.
- `busy`  out  1  high while a sweep is running (SETTLE or SAMPLE).
- `done`  out  1  one-cycle pulse when the sweep is complete.
- `gate_sel`  out  2  drives `LogicGates` sel (00 NOT, 01 AND, 10 OR, 11 XOR).
- `gate_a`  out  1  drives `LogicGates` A.
- `gate_b`  out  1  drives `LogicGates` B.
- `gate_y`  in  1  `LogicGates` Y.
- `truth_table`  out  16  captured results; bit index = {sel, a, b}.
- `mismatch`  out  1  sticky; set if any sample differs from golden. Present only with `LGSWEEP_CHECK_EN`.
- `err_count`  out  5  number of mismatching samples, 0..16. Present only with `LGSWEEP_CHECK_EN`.

## Operation
- **Vector index:** `idx[3:0]`. Outputs are `gate_sel = idx[3:2]`, `gate_a = idx[1]`, `gate_b = idx[0]`. All outputs are registered.
- **States:** IDLE, SETTLE, SAMPLE, DONE.
- **IDLE:** if `start` is high:
  - `idx` <= 0.
  - Drive vector 0.
  - Clear `truth_table`, `err_count` and `mismatch`.
  - Settle counter <= `SETTLE_CYCLES`.
  - Go to SETTLE.
- **SETTLE:** the counter decrements each cycle. When it reaches 1, go to SAMPLE.
- **SAMPLE:** `truth_table[idx]` <= `gate_y`.
  - If `idx` != 15: `idx` += 1, drive the next vector, reload the counter, go to SETTLE.
  - If `idx` == 15: go to DONE.
- **DONE:** `done` = 1 for this cycle only, then go to IDLE. Gate outputs hold the last vector (11, 1, 1) until the next start.
- **`start` handling:** ignored in SETTLE, SAMPLE and DONE. It is not queued.
- **NOT mode:** B is still swept. The golden value ignores B.
- **Golden table:** 16'h6E83.
  - Bits 3:0 are NOT (~A) = 0011.
  - Bits 7:4 are AND = 1000.
  - Bits 11:8 are OR = 1110.
  - Bits 15:12 are XOR = 0110.
- **Reset values:** `busy` 0, `done` 0, `gate_sel` 00, `gate_a` 0, `gate_b` 0, `truth_table` 0, `mismatch` 0, `err_count` 0, state IDLE.

## Timing
- **Per-vector latency:** `SETTLE_CYCLES` + 1 cycles.
- **Start to done:** start is sampled at edge T0. `done` is high in the cycle following edge T0 + 16·(`SETTLE_CYCLES`+1). `busy` is high from T0+1 through that same edge.
- **Settling margin:** `gate_*` change on the edge that enters SETTLE. `gate_y` is sampled no earlier than `SETTLE_CYCLES` full cycles later.
- **Bit updates:** one `truth_table` bit is written per SAMPLE cycle. Other bits hold their values.
- **Reset mid-sweep:** `rst_n` low at any edge forces all reset values at that edge, including `done` = 0. A partial table is discarded.
- **Simultaneous `start` and `rst_n` low:** reset wins.
- **`start` held high:** a new sweep begins on the first IDLE cycle after DONE, i.e. back-to-back sweeps with one IDLE cycle between them.

## Configuration
- **Macro:** `LGSWEEP_CHECK_EN`.
- **Defined:**
  - Each SAMPLE compares `gate_y` with golden bit `idx`.
  - On a difference, `err_count` increments (saturating at 16) and `mismatch` is set.
  - Both are cleared on start and on reset.
  - Both are valid when `done` pulses.
- **Undefined:** the `mismatch` and `err_count` ports and logic are absent. The block only captures `truth_table`.

## Test plan
- **Correct sweep:** correct `LogicGates` model, `SETTLE_CYCLES`=1, `start` pulse -> `done` 32 cycles after the accept edge, `truth_table` = 16'h6E83, `mismatch` 0, `err_count` 0.
- **Stuck-at-0 fault:** `gate_y` tied to 0 with `LGSWEEP_CHECK_EN` -> `truth_table` 16'h0000, `err_count` 8, `mismatch` 1.
- **Settle timing:** `SETTLE_CYCLES`=3 -> `done` 64 cycles after accept. Each `gate_*` vector holds for 4 cycles. Sequence observed on `{gate_sel, gate_a, gate_b}` is 0..15 in order.
- **Start while busy:** `start` pulsed at cycles 5 and 20 of a sweep -> ignored, single `done`, table 16'h6E83.
- **Reset mid-sweep:** `rst_n` low at cycle 10 -> next cycle all outputs at reset values. A new `start` then completes normally with 16'h6E83.
- **Held start:** `start` held high across two sweeps -> two `done` pulses 16·(S+1)+2 cycles apart, `truth_table` rewritten each time.

Source files
------------

// File: rtl/logicgates_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// logicgates_sweep_ctrl
//
// Built-in self-test sequencer for a LogicGates unit. A start pulse walks a
// 4-bit vector index through all 16 {sel, A, B} combinations. Each vector is
// held for SETTLE_CYCLES cycles, then Y is sampled for one cycle into a 16-bit
// truth table, where bit index = {sel, a, b}. A one-cycle done pulse marks
// completion.
//
// Optional feature macro: LGSWEEP_CHECK_EN
//   When defined, every sample is compared against the golden table
//   16'h6E83. A sticky mismatch flag and a saturating (0..16) error count are
//   added as ports.
//
// Parameters
//   SETTLE_CYCLES  cycles between driving a vector and sampling Y (1..15)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   sweep request, accepted only while idle
//   busy         out  high while settling/sampling
//   done         out  one-cycle completion pulse
//   gate_sel     out  LogicGates sel (00 NOT, 01 AND, 10 OR, 11 XOR)
//   gate_a       out  LogicGates A
//   gate_b       out  LogicGates B
//   gate_y       in   LogicGates Y
//   truth_table  out  captured results, bit index = {sel, a, b}
//   mismatch     out  sticky golden-compare failure   (LGSWEEP_CHECK_EN only)
//   err_count    out  number of mismatching samples   (LGSWEEP_CHECK_EN only)
// ---------------------------------------------------------------------------
module logicgates_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  gate_sel,
  output logic        gate_a,
  output logic        gate_b,
  input  logic        gate_y,
  output logic [15:0] truth_table
`ifdef LGSWEEP_CHECK_EN
  ,
  output logic        mismatch,
  output logic [4:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

`ifdef LGSWEEP_CHECK_EN
  localparam logic [15:0] GOLDEN = 16'h6E83;
`endif

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] table_q, table_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef LGSWEEP_CHECK_EN
  logic        mismatch_q, mismatch_d;
  logic [4:0]  err_q, err_d;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The settle counter is loaded with SETTLE_CYCLES and
  // SAMPLE is entered once it reads 1, so each vector lasts SETTLE_CYCLES
  // settle cycles plus one sample cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q <= 4'd1) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (idx_q == 4'd15) ? S_DONE : S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic. busy and done are derived from the next state so
  // that they are registered yet line up with the state they describe.
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    busy_d  = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d  = (state_d == S_DONE);
`ifdef LGSWEEP_CHECK_EN
    mismatch_d = mismatch_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = 4'd0;
          cnt_d   = SETTLE_INIT;
          table_d = 16'h0000;
`ifdef LGSWEEP_CHECK_EN
          mismatch_d = 1'b0;
          err_d      = 5'd0;
`endif
        end
      end
      S_SETTLE: begin
        if (cnt_q > 4'd1) cnt_d = cnt_q - 4'd1;
      end
      S_SAMPLE: begin
        table_d[idx_q] = gate_y;
`ifdef LGSWEEP_CHECK_EN
        if (gate_y != GOLDEN[idx_q]) begin
          mismatch_d = 1'b1;
          if (err_q != 5'd16) err_d = err_q + 5'd1;
        end
`endif
        // The index stops at 15 so the last vector stays on the gate pins
        // until the next sweep starts.
        if (idx_q != 4'd15) begin
          idx_d = idx_q + 4'd1;
          cnt_d = SETTLE_INIT;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      table_q <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LGSWEEP_CHECK_EN
      mismatch_q <= 1'b0;
      err_q      <= 5'd0;
`endif
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LGSWEEP_CHECK_EN
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign gate_sel    = idx_q[3:2];
  assign gate_a      = idx_q[1];
  assign gate_b      = idx_q[0];
  assign truth_table = table_q;
`ifdef LGSWEEP_CHECK_EN
  assign mismatch    = mismatch_q;
  assign err_count   = err_q;
`endif

endmodule

// File: tb/tb_logicgates_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_logicgates_sweep_ctrl
//
// Drives logicgates_sweep_ctrl with a behavioural LogicGates model. The model
// can flip any chosen set of truth-table entries to emulate faults. A
// reference model derives the expected timing (accept edge, vector schedule,
// done edge) and the expected table from plain arithmetic. When a start is
// accepted, an expected result record is queued. A monitor checks outputs
// every cycle and pops one record per done pulse.
// ---------------------------------------------------------------------------
module tb_logicgates_sweep_ctrl;

  localparam int S     = 3;
  localparam int SWEEP = 16 * (S + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, gate_a, gate_b, gate_y;
  logic [1:0]  gate_sel;
  logic [15:0] truth_table;
`ifdef LGSWEEP_CHECK_EN
  logic        mismatch;
  logic [4:0]  err_count;
`endif

  int checks = 0;
  int failures = 0;

  // Fault mask chosen by stimulus, and the mask latched by the model when a
  // sweep is accepted.
  logic [15:0] stim_mask = 16'h0;
  logic [15:0] active_mask = 16'h0;

  logicgates_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .gate_sel(gate_sel),
    .gate_a(gate_a),
    .gate_b(gate_b),
    .gate_y(gate_y),
    .truth_table(truth_table)
`ifdef LGSWEEP_CHECK_EN
    ,
    .mismatch(mismatch),
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Ideal LogicGates behaviour.
  function automatic logic gate_ref(input logic [3:0] v);
    logic a, b;
    a = v[1];
    b = v[0];
    case (v[3:2])
      2'b00:   return ~a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [15:0] ideal_table();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = gate_ref(4'(i));
    return t;
  endfunction

  assign gate_y = gate_ref({gate_sel, gate_a, gate_b}) ^ active_mask[{gate_sel, gate_a, gate_b}];

  typedef struct {
    int          done_edge;
    logic [15:0] tbl;
    int          errs;
  } exp_t;

  exp_t exp_q[$];

  int          cyc = 0;
  int          t0 = -1;
  int          next_ok = 0;
  logic [15:0] cur_table = 16'h0;
  logic [15:0] cur_mask = 16'h0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, actual, expected);
    end
  endtask

  // Reference model, evaluated at each rising edge with the sampled inputs.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst_n) begin
      t0 = -1;
      next_ok = 0;
      cur_table = 16'h0;
      cur_mask = 16'h0;
      exp_q.delete();
      active_mask <= 16'h0;
    end else if (start && cyc >= next_ok) begin
      t0 = cyc;
      next_ok = cyc + SWEEP + 2;
      cur_mask = stim_mask;
      cur_table = ideal_table() ^ stim_mask;
      e.done_edge = cyc + SWEEP;
      e.tbl = cur_table;
      e.errs = $countones(stim_mask);
      exp_q.push_back(e);
      active_mask <= stim_mask;
    end
  end

  // Monitor: checks all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    int          el, vec, n;
    logic        exp_busy, exp_done;
    logic [15:0] low, exp_tbl;
    exp_t        e;
    if (t0 < 0) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      vec = 0;
      low = 16'h0;
      exp_tbl = 16'h0;
    end else begin
      el = cyc - t0;
      exp_busy = (el < SWEEP);
      exp_done = (el == SWEEP);
      vec = el / (S + 1);
      if (vec > 15) vec = 15;
      n = el / (S + 1);
      if (n > 16) n = 16;
      low = 16'((33'h1 << n) - 33'h1);
      exp_tbl = cur_table & low;
    end
    checkOutput("busy", 32'(busy), 32'(exp_busy));
    checkOutput("done", 32'(done), 32'(exp_done));
    checkOutput("vector", 32'({gate_sel, gate_a, gate_b}), 32'(vec));
    checkOutput("truth_table", 32'(truth_table), 32'(exp_tbl));
`ifdef LGSWEEP_CHECK_EN
    checkOutput("err_count", 32'(err_count), 32'($countones(cur_mask & low)));
    checkOutput("mismatch", 32'(mismatch), 32'((cur_mask & low) != 16'h0));
`endif
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("done_without_sweep", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_done_edge", 32'(cyc), 32'(e.done_edge));
        checkOutput("sb_table", 32'(truth_table), 32'(e.tbl));
`ifdef LGSWEEP_CHECK_EN
        checkOutput("sb_err_count", 32'(err_count), 32'(e.errs));
        checkOutput("sb_mismatch", 32'(mismatch), 32'(e.errs != 0));
`endif
      end
    end
  end

  // One call = one cycle of input values, applied on the falling edge.
  task automatic applyStimulus(input logic s, input logic r);
    @(negedge clk);
    start = s;
    rst_n = r;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1);
  endtask

  task automatic pulseStart();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic waitDone(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL done_timeout at cycle %0d: got no done, want done within %0d cycles", cyc, budget);
    end
  endtask

  initial begin
    int gap, len;
    $display("[TB] starting, SETTLE_CYCLES=%0d", S);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    idleCycles(3);

    // Clean sweep.
    stim_mask = 16'h0;
    pulseStart();
    waitDone(SWEEP + 10);
    idleCycles(3);

    // Stuck-at-0 output: every 1 in the ideal table becomes a 0.
    stim_mask = ideal_table();
    pulseStart();
    waitDone(SWEEP + 10);
    idleCycles(2);

    // Start pulses while busy must be ignored.
    stim_mask = 16'h0;
    pulseStart();
    idleCycles(3);
    pulseStart();
    idleCycles(13);
    pulseStart();
    waitDone(SWEEP + 10);
    idleCycles(SWEEP + 4);

    // Reset mid-sweep, then a normal sweep.
    stim_mask = 16'h0;
    pulseStart();
    idleCycles(8);
    applyStimulus(1'b0, 1'b0);
    idleCycles(4);
    pulseStart();
    waitDone(SWEEP + 10);
    idleCycles(2);

    // Start held across two back-to-back sweeps.
    stim_mask = 16'(($urandom() & 32'h1) != 0 ? $urandom() : 32'h0);
    applyStimulus(1'b1, 1'b1);
    waitDone(SWEEP + 10);
    stim_mask = 16'($urandom());
    waitDone(SWEEP + 10);
    applyStimulus(1'b0, 1'b1);
    idleCycles(3);

    // Randomised sweeps with random faults, pulse lengths and resets.
    for (int it = 0; it < 8; it++) begin
      stim_mask = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom());
      gap = $urandom_range(0, 5);
      len = $urandom_range(1, 3);
      idleCycles(gap);
      for (int i = 0; i < len; i++) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        idleCycles($urandom_range(0, SWEEP - 6));
        applyStimulus(1'b0, 1'b0);
        idleCycles(2);
      end else begin
        waitDone(SWEEP + 10);
      end
    end
    idleCycles(SWEEP + 5);

    checkOutput("pending_results", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
